// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: next-PC select codes, FSM states and reset/exception constants.
// NPC_* encodings are shared with ctrl; S_* encodings are private to the fetch FSM.
package pc_fetch_unit_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_EXCEPT = 3'd3;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR  = 32'h0000_4180;
    localparam logic [4:0]  DEF_EXC_CODE_RI = 5'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_EXCPT = 3'd3
    } state_e;

    // Word offset of a conditional branch, sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Next-PC target arithmetic (sequential, branch, jump, exception vector).
// Latency: purely combinational.
// Backpressure: none; the caller decides when npc is consumed.
module npc_calc
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  NPCOp,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[31:26];

    // Modulo-2^32 adds: a fetch at 32'hFFFF_FFFC sequences to address 0.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        npc = pc_plus4;
        case (NPCOp)
            NPC_BRANCH: npc = pc_plus4 + branch_offset(instr[15:0]);
            NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_EXCEPT: npc = EXC_VECTOR;
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC; fetches over req/ack imem and holds one instruction in execute for ctrl.
// Latency: >=2 cycles per instruction (FETCH with zero-wait ack, EXEC); exceptions add one EXCPT cycle.
// Backpressure: imem_req held until imem_ack; stall freezes the instruction in execute.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
    parameter logic [4:0]  EXC_CODE_RI = DEF_EXC_CODE_RI
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [2:0]  NPCOp,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rt,
    output logic        nop,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        flush,
    output logic        retired
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] epc_q;
    logic [4:0]  cause_q;
    logic        req_q;
    logic        nop_q;
    logic        flush_q;
    logic        retired_q;
    logic [31:0] npc_d;
    logic [31:0] pc_plus4_d;

    npc_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_calc (
        .pc       (pc_q),
        .instr    (instr_q),
        .NPCOp    (NPCOp),
        .npc      (npc_d),
        .pc_plus4 (pc_plus4_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            req_q     <= 1'b0;
            nop_q     <= 1'b1;
            flush_q   <= 1'b0;
            retired_q <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle unless re-armed below.
            flush_q   <= 1'b0;
            retired_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (req_q && imem_ack) begin
                        instr_q <= imem_rdata;
                        nop_q   <= 1'b0;
                        req_q   <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc_q  <= npc_d;
                        nop_q <= 1'b1;
                        if (NPCOp == NPC_EXCEPT) begin
                            epc_q   <= pc_q;
                            cause_q <= EXC_CODE_RI;
                            flush_q <= 1'b1;
                            state_q <= S_EXCPT;
                        end else begin
                            retired_q <= 1'b1;
                            req_q     <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                S_EXCPT: begin
                    req_q   <= 1'b1;
                    state_q <= S_FETCH;
                end
                default: begin
                    req_q   <= 1'b0;
                    nop_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign rt        = instr_q[20:16];
    assign nop       = nop_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_d;
    assign epc       = epc_q;
    assign cause     = cause_q;
    assign flush     = flush_q;
    assign retired   = retired_q;

endmodule
